// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port load/store controller with alignment checks, extraction and sub-word read-modify-write.
// Byte/halfword support is enabled by defining MEM_CTRL_SUBWORD_EN; otherwise only word accesses succeed.
module mem_ctrl #(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [MEM_AW+1:0] addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DW-1:0]     rdata_o,
  output logic              mem_rw_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i
);
`ifdef MEM_CTRL_SUBWORD_EN
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, DONE} state_t;
`endif
  state_t            state_q, state_d;
  logic [MEM_AW+1:0] addr_q;
  logic [DW-1:0]     wdata_q, rdata_q, ld_d;
  logic              err_q, bad, acc;
  assign acc = state_q == IDLE && req_i;
`ifdef MEM_CTRL_SUBWORD_EN
  logic [1:0]    size_q;
  logic          uns_q;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [4:0]    sh;
  logic [DW-1:0] lane, merged;
  always_comb begin
    bad    = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    sh     = {addr_q[1:0], 3'b000};
    b      = 8'(mem_rdata_i >> sh);
    h      = 16'(mem_rdata_i >> {addr_q[1], 4'b0000});
    ld_d   = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} : size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : mem_rdata_i;
    lane   = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (mem_rdata_i & ~lane) | ((wdata_q << sh) & lane);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      size_q <= 2'b00;
      uns_q  <= 1'b0;
    end else if (acc) begin
      size_q <= size_i;
      uns_q  <= uns_i;
    end
`else
  logic unused_sub;
  assign bad        = size_i != 2'b10 || addr_i[1:0] != 2'b00;
  assign ld_d       = mem_rdata_i;
  assign unused_sub = ^{uns_i, addr_q[1:0]};
`endif
  // Access type is resolved at acceptance and carried by the state itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef MEM_CTRL_SUBWORD_EN
      IDLE:    if (req_i) state_d = bad ? DONE : !we_i ? RD : size_i == 2'b10 ? WR : RMW_RD;
      RMW_RD:  state_d = WR;
`else
      IDLE:    if (req_i) state_d = bad ? DONE : !we_i ? RD : WR;
`endif
      RD, WR:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        err_q   <= bad;
      end
      if (state_q == RD) rdata_q <= ld_d;
`ifdef MEM_CTRL_SUBWORD_EN
      if (state_q == RMW_RD) wdata_q <= merged;
`endif
    end
  // Gating with rst kills a write in the same cycle reset is asserted.
  assign ready_o     = rst && state_q == IDLE;
  assign done_o      = state_q == DONE;
  assign err_o       = done_o && err_q;
  assign mem_rw_o    = rst && state_q == WR;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q[MEM_AW+1:2];
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven directed bench for mem_ctrl with a behavioural word memory.
// Expectations switch on MEM_CTRL_SUBWORD_EN to match the build under test.
module tb_mem_ctrl;
  localparam int AW = 10;
  logic          clk = 1'b0, rst = 1'b0, req_i = 1'b0, we_i = 1'b0, uns_i = 1'b0;
  logic [1:0]    size_i = 2'b10;
  logic [AW+1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic          ready_o, done_o, err_o, mem_rw_o;
  logic [31:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            checks = 0, errors = 0;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_rw;
    logic [31:0]   exp_rdata;
    logic [31:0]   exp_word;
  } vec_t;
  vec_t vecs[$];

  mem_ctrl #(.MEM_AW(AW), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i), .uns_i(uns_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk) if (mem_rw_o) mem[mem_addr_o] <= mem_wdata_o;

  function automatic vec_t v(input logic we, input logic [1:0] size, input logic uns, input logic [AW+1:0] addr,
                             input logic [31:0] wdata, input logic exp_err, input int exp_lat, input int exp_rw,
                             input logic [31:0] exp_rdata, input logic [31:0] exp_word);
    vec_t t;
    t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata; t.exp_err = exp_err;
    t.exp_lat = exp_lat; t.exp_rw = exp_rw; t.exp_rdata = exp_rdata; t.exp_word = exp_word;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge clk);
    while (!ready_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk(name, {31'd0, ready_o}, 32'd1);
  endtask

  task automatic do_access(input int i, input vec_t t);
    int lat = 0, rw_at = 0;
    logic err_idle = 1'b0, got_err = 1'b0;
    logic [31:0] got_rd = '0;
    wait_ready($sformatf("v%0d_ready", i));
    req_i = 1'b1; we_i = t.we; size_i = t.size; uns_i = t.uns; addr_i = t.addr; wdata_i = t.wdata;
    @(posedge clk);
    #1 req_i = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_rw_o) rw_at = rw_at == 0 ? c : 99;
      if (err_o && !done_o) err_idle = 1'b1;
      if (done_o) begin
        lat = c;
        got_err = err_o;
        got_rd = rdata_o;
      end
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(t.exp_lat));
    chk($sformatf("v%0d_err", i), {31'd0, got_err}, {31'd0, t.exp_err});
    chk($sformatf("v%0d_rdata", i), got_rd, t.exp_rdata);
    chk($sformatf("v%0d_rw_cycle", i), 32'(rw_at), 32'(t.exp_rw));
    chk($sformatf("v%0d_mem_word", i), mem[t.addr[AW+1:2]], t.exp_word);
    chk($sformatf("v%0d_err_without_done", i), {31'd0, err_idle}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_exp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h020 >> 2] = 32'h1122_3344;
    mem[12'h030 >> 2] = 32'h0000_80F0;
    mem[12'h040 >> 2] = 32'h5555_5555;
`ifdef MEM_CTRL_SUBWORD_EN
    vecs.push_back(v(1, 2'b10, 0, 12'h010, 32'hDEAD_BEEF, 0, 2, 1, 32'h0000_0000, 32'hDEAD_BEEF));
    vecs.push_back(v(0, 2'b10, 0, 12'h010, 32'h0,         0, 2, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(v(1, 2'b00, 0, 12'h022, 32'h0000_00AA, 0, 3, 2, 32'hDEAD_BEEF, 32'h11AA_3344));
    vecs.push_back(v(0, 2'b00, 0, 12'h030, 32'h0,         0, 2, 0, 32'hFFFF_FFF0, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b01, 1, 12'h030, 32'h0,         0, 2, 0, 32'h0000_80F0, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b10, 0, 12'h031, 32'h0,         1, 1, 0, 32'h0000_80F0, 32'h0000_80F0));
    vecs.push_back(v(1, 2'b01, 0, 12'h033, 32'h0000_FFFF, 1, 1, 0, 32'h0000_80F0, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b01, 0, 12'h030, 32'h0,         0, 2, 0, 32'hFFFF_80F0, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b00, 1, 12'h031, 32'h0,         0, 2, 0, 32'h0000_0080, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b00, 0, 12'h031, 32'h0,         0, 2, 0, 32'hFFFF_FF80, 32'h0000_80F0));
    vecs.push_back(v(1, 2'b01, 0, 12'h032, 32'h0000_1234, 0, 3, 2, 32'hFFFF_FF80, 32'h1234_80F0));
    vecs.push_back(v(0, 2'b10, 0, 12'h030, 32'h0,         0, 2, 0, 32'h1234_80F0, 32'h1234_80F0));
    vecs.push_back(v(0, 2'b11, 0, 12'h030, 32'h0,         1, 1, 0, 32'h1234_80F0, 32'h1234_80F0));
    vecs.push_back(v(1, 2'b00, 0, 12'h023, 32'h0000_005A, 0, 3, 2, 32'h1234_80F0, 32'h5AAA_3344));
    vecs.push_back(v(0, 2'b01, 1, 12'h022, 32'h0,         0, 2, 0, 32'h0000_5AAA, 32'h5AAA_3344));
    hold_exp = 32'h1234_80F0;
`else
    vecs.push_back(v(1, 2'b10, 0, 12'h010, 32'hDEAD_BEEF, 0, 2, 1, 32'h0000_0000, 32'hDEAD_BEEF));
    vecs.push_back(v(0, 2'b10, 0, 12'h010, 32'h0,         0, 2, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(v(0, 2'b00, 0, 12'h000, 32'h0,         1, 1, 0, 32'hDEAD_BEEF, 32'h0000_0000));
    vecs.push_back(v(0, 2'b10, 0, 12'h031, 32'h0,         1, 1, 0, 32'hDEAD_BEEF, 32'h0000_80F0));
    vecs.push_back(v(1, 2'b01, 0, 12'h033, 32'h0000_FFFF, 1, 1, 0, 32'hDEAD_BEEF, 32'h0000_80F0));
    vecs.push_back(v(1, 2'b00, 0, 12'h022, 32'h0000_00AA, 1, 1, 0, 32'hDEAD_BEEF, 32'h1122_3344));
    vecs.push_back(v(0, 2'b10, 0, 12'h030, 32'h0,         0, 2, 0, 32'h0000_80F0, 32'h0000_80F0));
    vecs.push_back(v(0, 2'b10, 1, 12'h020, 32'h0,         0, 2, 0, 32'h1122_3344, 32'h1122_3344));
    vecs.push_back(v(0, 2'b11, 0, 12'h020, 32'h0,         1, 1, 0, 32'h1122_3344, 32'h1122_3344));
    vecs.push_back(v(1, 2'b10, 0, 12'h024, 32'hCAFE_F00D, 0, 2, 1, 32'h1122_3344, 32'hCAFE_F00D));
    vecs.push_back(v(0, 2'b10, 0, 12'h024, 32'h0,         0, 2, 0, 32'hCAFE_F00D, 32'hCAFE_F00D));
    hold_exp = 32'h0000_80F0;
`endif
    #12;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("first_cycle_ready", {31'd0, ready_o}, 32'd1);
    foreach (vecs[i]) do_access(i, vecs[i]);
    // req held high with a changing address: ignored while busy, re-accepted right after done.
    wait_ready("hold_ready");
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; uns_i = 1'b0; addr_i = 12'h010;
    @(posedge clk);
    #1 addr_i = 12'h030;
    @(negedge clk);
    chk("hold_addr_latched", 32'(mem_addr_o), 32'h4);
    chk("hold_no_done_n1", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    chk("hold_done_n2", {31'd0, done_o}, 32'd1);
    chk("hold_rdata1", rdata_o, 32'hDEAD_BEEF);
    chk("hold_not_ready_in_done", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    chk("hold_ready_after_done", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    chk("hold_addr2", 32'(mem_addr_o), 32'hC);
    chk("hold_no_done_n4", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    chk("hold_done2", {31'd0, done_o}, 32'd1);
    chk("hold_rdata2", rdata_o, hold_exp);
    // Reset asserted in the WR cycle of a word store must suppress the write.
    wait_ready("rstwr_ready");
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 12'h040; wdata_i = 32'h1234_5678;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    chk("rstwr_rw_in_wr", {31'd0, mem_rw_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstwr_rw_dropped", {31'd0, mem_rw_o}, 32'd0);
    chk("rstwr_ready_low", {31'd0, ready_o}, 32'd0);
    chk("rstwr_done_low", {31'd0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstwr_mem_unchanged", mem[12'h040 >> 2], 32'h5555_5555);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr_ready_after", {31'd0, ready_o}, 32'd1);
    chk("rstwr_no_done", {31'd0, done_o}, 32'd0);
    chk("rstwr_rdata_cleared", rdata_o, 32'd0);
    do_access(99, v(0, 2'b10, 0, 12'h040, 32'h0, 0, 2, 0, 32'h5555_5555, 32'h5555_5555));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_AW, default 10: word-address width of the memory port.
REQ-002 Parameter DW, default 32: data width; fixed at 32 in this release.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  core access request; sampled only while ready_o=1.
REQ-006 we_i  input  1  1 = store, 0 = load.
REQ-007 size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
REQ-008 uns_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 addr_i  input  MEM_AW+2  byte address.
REQ-010 wdata_i  input  32  store data, right-aligned.
REQ-011 ready_o  output  1  controller idle; accepts req_i.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 err_o  output  1  valid with done_o: misaligned or unsupported access.
REQ-014 rdata_o  output  32  load result; held until the next completed load.
REQ-015 mem_rw_o  output  1  1 = write the memory word this cycle.
REQ-016 mem_addr_o  output  MEM_AW  memory word address (addr[MEM_AW+1:2]).
REQ-017 mem_wdata_o  output  32  memory write data.
REQ-018 mem_rdata_i  input  32  memory combinational read data for mem_addr_o.

Function
REQ-019 The FSM SHALL have states IDLE, RD, RMW_RD, WR, DONE; ready_o=1 only in IDLE.
REQ-020 On req_i=1 in IDLE (cycle N), the controller SHALL latch we_i, size_i, uns_i, addr_i, wdata_i.
REQ-021 Misalignment (half with addr[0]=1, word with addr[1:0]!=0, size 11) SHALL go to DONE with err_o=1, no memory write, rdata_o unchanged.
REQ-022 Aligned load: IDLE->RD->DONE; rdata_o captured at the end of RD; done_o high in cycle N+2.
REQ-023 Load extraction SHALL select byte addr[1:0] or halfword addr[1], little-endian, extended per uns_i.
REQ-024 Word store: IDLE->WR->DONE; mem_rw_o=1 in cycle N+1 only; done_o in N+2.
REQ-025 Sub-word store: IDLE->RMW_RD->WR->DONE; RMW_RD captures mem_rdata_i; WR writes the word with only the addressed lanes replaced; done_o in N+3.
REQ-026 mem_rw_o SHALL be 0 in every state other than WR.
REQ-027 mem_addr_o SHALL hold the latched address from acceptance until the next acceptance.
REQ-028 DONE SHALL always return to IDLE; back-to-back requests SHALL be accepted in the cycle after done_o.
REQ-029 req_i SHALL be ignored outside IDLE; err_o SHALL be 0 whenever done_o=0.

Reset
REQ-030 While rst=0: state IDLE; ready_o, done_o, err_o, mem_rw_o = 0; rdata_o, mem_addr_o, mem_wdata_o = 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately; mem_rw_o SHALL drop combinationally, so no write occurs; no done_o for the aborted access.
REQ-032 ready_o SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-033 Macro MEM_CTRL_SUBWORD_EN defined: byte/halfword loads and stores are supported as above.
REQ-034 Macro MEM_CTRL_SUBWORD_EN undefined: RMW_RD and the extraction logic SHALL be omitted; any size_i != 10 SHALL complete as an error per REQ-021.

Verification
REQ-035 Word store 0xDEADBEEF to addr 0x010, then load word from 0x010 -> mem_rw_o=1 in N+1 only; rdata_o=0xDEADBEEF; done_o in N+2.
REQ-036 With word 0x11223344 at 0x020, store byte 0xAA to 0x022 -> memory word 0x11AA3344; done_o in N+3.
REQ-037 With word 0x0000_80F0 at 0x030: signed byte load from 0x030 -> 0xFFFFFFF0; unsigned halfword load from 0x030 -> 0x000080F0.
REQ-038 Word load from 0x031 and halfword store to 0x033 -> done_o in N+1 with err_o=1; no mem_rw_o pulse; memory unchanged.
REQ-039 rst pulled low during the WR cycle of a word store to 0x040 -> mem_rw_o=0 immediately; memory at 0x040 unchanged; ready_o=1 after release.
REQ-040 MEM_CTRL_SUBWORD_EN undefined: byte load from 0x000 -> err_o=1 with done_o; word accesses still pass REQ-035.
